mem_wb_pipe: RTL
================

# mem_wb_pipe

Parametrised MEM→WB pipeline stage. It replaces the single-field read-data latch with a valid/ready handshake register, backed by a one-entry skid buffer so upstream never sees a combinational ready path. It carries all write-back fields (load data, ALU result, destination register, control) and performs load sub-word selection/extension. It drives the final register-file write data, a forwarding tap and a synchronous flush.

## Interface
- DATA_W, 32, datapath width (must be 32 for load extension; other widths pass ReadData unextended)
- REG_W, 5, register-index width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous: drop all held entries this cycle
- mem_valid  in  1  MEM entry present
- mem_ready  out  1  stage can accept; equals !skid_v (registered, no comb path from wb_ready)
- mem_ReadData  in  DATA_W  raw memory word
- mem_AluResult  in  DATA_W  ALU result / address
- mem_Rd  in  REG_W  destination register
- mem_RegWrite  in  1  writes register file
- mem_MemToReg  in  1  1 = load data, 0 = ALU result
- mem_LoadType  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes = LW
- mem_ByteOff  in  2  address[1:0] of the load
- wb_valid  out  1  main register holds an entry
- wb_ready  in  1  WB consumes the entry
- wb_Rd  out  REG_W  registered destination
- wb_RegWrite  out  1  wb_valid & RegWrite & (Rd != 0)
- wb_WriteData  out  DATA_W  final write data (comb from main register)
- fwd_Rd / fwd_Data / fwd_Valid  out  REG_W / DATA_W / 1  forwarding tap; mirror wb_Rd, wb_WriteData, wb_RegWrite

## Operation
- Two storage slots: main (drives outputs), skid. Each slot has a valid bit plus all input fields.
- in_fire = mem_valid & mem_ready & !flush; out_fire = wb_valid & wb_ready.
- Per-cycle update, in priority order:
  - flush: main_v ← 0, skid_v ← 0. Data registers may keep stale values. Incoming is not captured.
  - main empty or out_fire:
    - if skid_v: main ← skid. Skid ← incoming if in_fire, else skid_v ← 0.
    - else: main ← incoming, and main_v ← in_fire.
  - main full and !out_fire: if in_fire, skid ← incoming, skid_v ← 1.
- mem_ready = !skid_v. Because skid full forces mem_ready low, in_fire with a full skid cannot occur.
- Ordering is strictly FIFO: no entry is lost or duplicated.
- Load extension is combinational from the main fields:
  - Byte: ReadData[8·off+7 : 8·off].
  - Half: off[1] ? [31:16] : [15:0]. off[0] is ignored, so misaligned halves are not trapped.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the whole word.
- wb_WriteData = MemToReg ? extended : AluResult.
- Rd = 0 never asserts wb_RegWrite or fwd_Valid.

## Timing
- Reset (async assert, sync release): main_v = skid_v = 0, all data/control registers 0. Consequently:
  - mem_ready = 1, wb_valid = 0, wb_RegWrite = 0, wb_Rd = 0, wb_WriteData = 0.
- Latency: an entry accepted in cycle N is on wb_* in cycle N+1 when main is empty or draining.
- Throughput: 1 entry/cycle while wb_ready = 1.
- A wb_ready deassertion absorbs exactly one further entry (into skid). mem_ready falls the following cycle.
- Releasing backpressure:
  - skid drains into main on the first out_fire.
  - mem_ready returns high the cycle after skid empties.
  - No bubble if mem_valid stays high.
- Simultaneous flush and out_fire: the entry counts as consumed by WB this cycle, and both slots are empty next cycle.
- Reset mid-operation discards both slots immediately (asynchronous).

## Test plan
- Reset asserted mid-stream with both slots full → outputs immediately: wb_valid = 0, mem_ready = 1, wb_WriteData = 0. After release, first accepted entry appears next cycle.
- Stream 4 ALU ops (Rd = 1..4, AluResult = 0x10..0x13) with wb_ready = 1 → wb sequence 1..4, one per cycle, 1-cycle latency.
- wb_ready low for 3 cycles while mem_valid held with entries A, B, C:
  - A is in main, B is in skid, mem_ready = 0, C is held upstream.
  - After release: order A, B, C with no loss.
- Loads from ReadData = 0x80F1_7F02:
  - LB off 3 → 0xFFFF_FF80
  - LBU off 2 → 0x0000_00F1
  - LH off 0 → 0x0000_7F02
  - LHU off 2 → 0x0000_80F1
  - LW → 0x80F1_7F02
- Rd = 0 with RegWrite = 1 → wb_valid = 1, wb_RegWrite = 0, fwd_Valid = 0.
- flush with main and skid full and mem_valid = 1 → next cycle wb_valid = 0, mem_ready = 1, and the incoming entry is not captured.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline stage: valid/ready register with a one-entry skid buffer,
// load sub-word selection/extension, register-file write data and forwarding tap.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [DATA_W-1:0] mem_ReadData,
  input  logic [DATA_W-1:0] mem_AluResult,
  input  logic [REG_W-1:0]  mem_Rd,
  input  logic              mem_RegWrite,
  input  logic              mem_MemToReg,
  input  logic [2:0]        mem_LoadType,
  input  logic [1:0]        mem_ByteOff,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_Rd,
  output logic              wb_RegWrite,
  output logic [DATA_W-1:0] wb_WriteData,
  output logic [REG_W-1:0]  fwd_Rd,
  output logic [DATA_W-1:0] fwd_Data,
  output logic              fwd_Valid
);

  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_to_reg;
    logic [2:0]        load_type;
    logic [1:0]        byte_off;
  } slot_t;

  slot_t main_q, skid_q, incoming;
  logic  main_v, skid_v;
  logic  in_fire, out_fire;
  logic [DATA_W-1:0] ext_data;

  assign incoming = '{read_data:  mem_ReadData,
                      alu:        mem_AluResult,
                      rd:         mem_Rd,
                      reg_write:  mem_RegWrite,
                      mem_to_reg: mem_MemToReg,
                      load_type:  mem_LoadType,
                      byte_off:   mem_ByteOff};

  // Ready depends only on the registered skid flag, never on wb_ready.
  assign mem_ready = !skid_v;
  assign in_fire   = mem_valid & mem_ready & !flush;
  assign out_fire  = main_v & wb_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_fire) begin
      if (skid_v) begin
        main_q <= skid_q;
        if (in_fire) skid_q <= incoming;
        else         skid_v <= 1'b0;
      end else begin
        main_q <= incoming;
        main_v <= in_fire;
      end
    end else if (in_fire) begin
      skid_q <= incoming;
      skid_v <= 1'b1;
    end
  end

  generate
    if (DATA_W == 32) begin : g_ext
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      always_comb begin
        byte_sel = main_q.read_data[7:0];
        case (main_q.byte_off)
          2'd1:    byte_sel = main_q.read_data[15:8];
          2'd2:    byte_sel = main_q.read_data[23:16];
          2'd3:    byte_sel = main_q.read_data[31:24];
          default: byte_sel = main_q.read_data[7:0];
        endcase
        // Misaligned halves are not trapped: off[0] is ignored.
        half_sel = main_q.byte_off[1] ? main_q.read_data[31:16] : main_q.read_data[15:0];
        case (main_q.load_type)
          3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
          3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
          3'b100:  ext_data = {24'd0, byte_sel};
          3'b101:  ext_data = {16'd0, half_sel};
          default: ext_data = main_q.read_data;
        endcase
      end
    end else begin : g_pass
      assign ext_data = main_q.read_data;
    end
  endgenerate

  assign wb_valid     = main_v;
  assign wb_Rd        = main_q.rd;
  assign wb_RegWrite  = main_v & main_q.reg_write & (main_q.rd != '0);
  assign wb_WriteData = main_q.mem_to_reg ? ext_data : main_q.alu;

  assign fwd_Rd    = wb_Rd;
  assign fwd_Data  = wb_WriteData;
  assign fwd_Valid = wb_RegWrite;

endmodule
